instr_decoder_pipe: RTL and testbench

- Next-generation per-core instruction decoder.
- Decodes an instruction word into register fields, immediate, NZP mask and control signals.
- Uses valid/ready handshakes on both sides with a 2-entry skid buffer, so fetch and the execute stage decouple without bubbles.
- Field widths are parametrised; it adds illegal-opcode detection, a RET-triggered halt state with flush recovery, and a decode counter.

---
 rtl/gpu_isa_pkg.sv | 107 ++++++++++
 rtl/decode_skid_buffer.sv | 53 +++++
 rtl/instr_decoder_pipe.sv | 117 +++++++++++
 tb/tb_instr_decoder_pipe.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the GPU core: opcodes, mux encodings, core states,
// the decoded bundle payload and the combinational decode function.
package gpu_isa_pkg;

   localparam int unsigned OPCODE_WIDTH = 4;
   localparam int unsigned NZP_WIDTH    = 3;
   localparam int unsigned REG_ADDR_MAX = 8;
   localparam int unsigned IMM_MAX      = 16;
   localparam int unsigned INSTR_MAX    = 32;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_BRNZP = 4'h1;
   localparam logic [3:0] OP_CMP   = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_MUL   = 4'h5;
   localparam logic [3:0] OP_DIV   = 4'h6;
   localparam logic [3:0] OP_LDR   = 4'h7;
   localparam logic [3:0] OP_STR   = 4'h8;
   localparam logic [3:0] OP_CONST = 4'h9;
   localparam logic [3:0] OP_RET   = 4'hF;

   localparam logic [1:0] REG_IN_ALU   = 2'b00;
   localparam logic [1:0] REG_IN_MEM   = 2'b01;
   localparam logic [1:0] REG_IN_CONST = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_MUL = 2'b10;
   localparam logic [1:0] ALU_DIV = 2'b11;

   typedef enum logic {
      CORE_RUN    = 1'b0,
      CORE_HALTED = 1'b1
   } core_state_e;

   // Fields are sized for the widest supported layout; narrower cores zero-extend.
   typedef struct packed {
      logic [REG_ADDR_MAX-1:0] rd;
      logic [REG_ADDR_MAX-1:0] rs;
      logic [REG_ADDR_MAX-1:0] rt;
      logic [NZP_WIDTH-1:0]    nzp;
      logic [IMM_MAX-1:0]      imm;
      logic                    reg_write_enable;
      logic                    mem_read_enable;
      logic                    mem_write_enable;
      logic                    nzp_write_enable;
      logic                    alu_output_mux;
      logic                    pc_mux;
      logic                    ret;
      logic [1:0]              reg_input_mux;
      logic [1:0]              alu_arithmetic_mux;
      logic                    illegal;
   } decoded_bundle_t;

   function automatic logic [INSTR_MAX-1:0] field_mask(input int unsigned w);
      return (INSTR_MAX'(1) << w) - INSTR_MAX'(1);
   endfunction

   // Widths are elaboration constants at every call site, so this reduces to wiring.
   function automatic decoded_bundle_t decode_instr(input logic [INSTR_MAX-1:0] instr,
                                                    input int unsigned instr_w,
                                                    input int unsigned reg_w,
                                                    input int unsigned imm_w);
      decoded_bundle_t d;
      logic [OPCODE_WIDTH-1:0] opcode;
      d      = '0;
      opcode = OPCODE_WIDTH'(instr >> (instr_w - OPCODE_WIDTH));
      d.rd   = REG_ADDR_MAX'((instr >> (instr_w - OPCODE_WIDTH - reg_w)) & field_mask(reg_w));
      d.rs   = REG_ADDR_MAX'((instr >> (instr_w - OPCODE_WIDTH - 2*reg_w)) & field_mask(reg_w));
      d.rt   = REG_ADDR_MAX'((instr >> (instr_w - OPCODE_WIDTH - 3*reg_w)) & field_mask(reg_w));
      d.nzp  = NZP_WIDTH'(d.rd >> (reg_w - NZP_WIDTH));
      d.imm  = IMM_MAX'(instr & field_mask(imm_w));
      case (opcode)
         OP_NOP:   ;
         OP_BRNZP: d.pc_mux = 1'b1;
         OP_CMP: begin
            d.alu_output_mux   = 1'b1;
            d.nzp_write_enable = 1'b1;
         end
         OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
            d.reg_write_enable = 1'b1;
            d.reg_input_mux    = REG_IN_ALU;
            case (opcode)
               OP_SUB:  d.alu_arithmetic_mux = ALU_SUB;
               OP_MUL:  d.alu_arithmetic_mux = ALU_MUL;
               OP_DIV:  d.alu_arithmetic_mux = ALU_DIV;
               default: d.alu_arithmetic_mux = ALU_ADD;
            endcase
         end
         OP_LDR: begin
            d.reg_write_enable = 1'b1;
            d.reg_input_mux    = REG_IN_MEM;
            d.mem_read_enable  = 1'b1;
         end
         OP_STR:   d.mem_write_enable = 1'b1;
         OP_CONST: begin
            d.reg_write_enable = 1'b1;
            d.reg_input_mux    = REG_IN_CONST;
         end
         OP_RET:   d.ret = 1'b1;
         default:  d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry valid/ready register stage: an output register backed by one skid
// entry that catches a word accepted while the output is stalled.
module decode_skid_buffer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             skid_valid_q;
   logic [WIDTH-1:0] skid_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_q;

   assign in_ready  = !skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_q;

   // Skid drains first so order is preserved; push is only legal while in_ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         out_q        <= '0;
      end else if (flush) begin
         skid_valid_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (push) begin
            out_q       <= push_data;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (push) begin
         skid_q       <= push_data;
         skid_valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/instr_decoder_pipe.sv
// Pipelined instruction decoder: decodes each accepted word into a control
// bundle, buffers it through a skid stage and halts intake after a RET.
module instr_decoder_pipe
   import gpu_isa_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = 4,
   parameter int unsigned IMM_WIDTH      = 8,
   parameter int unsigned INSTR_WIDTH    = 16,
   parameter int unsigned COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSTR_WIDTH-1:0]    instruction,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [REG_ADDR_WIDTH-1:0] decoded_rd_address,
   output logic [REG_ADDR_WIDTH-1:0] decoded_rs_address,
   output logic [REG_ADDR_WIDTH-1:0] decoded_rt_address,
   output logic [2:0]                decoded_nzp,
   output logic [IMM_WIDTH-1:0]      decoded_immediate,
   output logic                      decoded_reg_write_enable,
   output logic                      decoded_mem_read_enable,
   output logic                      decoded_mem_write_enable,
   output logic                      decoded_nzp_write_enable,
   output logic                      decoded_alu_output_mux,
   output logic                      decoded_pc_mux,
   output logic                      decoded_ret,
   output logic [1:0]                decoded_reg_input_mux,
   output logic [1:0]                decoded_alu_arithmetic_mux,
   output logic                      decoded_illegal,
   output logic                      halted,
   output logic [COUNT_WIDTH-1:0]    decode_count
);

   localparam int unsigned BUNDLE_WIDTH = $bits(decoded_bundle_t);

   if (INSTR_WIDTH < OPCODE_WIDTH + 3*REG_ADDR_WIDTH || INSTR_WIDTH < OPCODE_WIDTH + IMM_WIDTH ||
       INSTR_WIDTH > INSTR_MAX || REG_ADDR_WIDTH > REG_ADDR_MAX || REG_ADDR_WIDTH < NZP_WIDTH ||
       IMM_WIDTH > IMM_MAX) begin : g_bad_params
      $error("instr_decoder_pipe: field widths do not fit the instruction word");
   end

   core_state_e                 state_q;
   core_state_e                 state_d;
   decoded_bundle_t             dec_c;
   decoded_bundle_t             out_b;
   logic [BUNDLE_WIDTH-1:0]     unused_bundle;
   logic                        buf_in_ready;
   logic                        in_fire;
   logic                        out_fire;
   logic [COUNT_WIDTH-1:0]      count_q;

   assign dec_c    = decode_instr(INSTR_MAX'(instruction), INSTR_WIDTH, REG_ADDR_WIDTH, IMM_WIDTH);
   assign in_ready = !reset && !flush && (state_q == CORE_RUN) && buf_in_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   decode_skid_buffer #(
      .WIDTH(BUNDLE_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (in_fire),
      .push_data (dec_c),
      .in_ready  (buf_in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_b)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= CORE_RUN;
      else       state_q <= state_d;
   end

   // Intake closes once a RET is accepted; only a flush reopens it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CORE_RUN:    if (in_fire && dec_c.ret) state_d = CORE_HALTED;
         CORE_HALTED: state_d = CORE_HALTED;
         default:     state_d = CORE_RUN;
      endcase
      if (flush) state_d = CORE_RUN;
   end

   always_ff @(posedge clk) begin
      if (reset)         count_q <= '0;
      else if (out_fire) count_q <= count_q + COUNT_WIDTH'(1);
   end

   assign halted       = (state_q == CORE_HALTED);
   assign decode_count = count_q;

   // Bundle is held at the widest layout; only this core's low bits leave the block.
   assign unused_bundle              = out_b;
   assign decoded_rd_address         = REG_ADDR_WIDTH'(out_b.rd);
   assign decoded_rs_address         = REG_ADDR_WIDTH'(out_b.rs);
   assign decoded_rt_address         = REG_ADDR_WIDTH'(out_b.rt);
   assign decoded_nzp                = out_b.nzp;
   assign decoded_immediate          = IMM_WIDTH'(out_b.imm);
   assign decoded_reg_write_enable   = out_b.reg_write_enable;
   assign decoded_mem_read_enable    = out_b.mem_read_enable;
   assign decoded_mem_write_enable   = out_b.mem_write_enable;
   assign decoded_nzp_write_enable   = out_b.nzp_write_enable;
   assign decoded_alu_output_mux     = out_b.alu_output_mux;
   assign decoded_pc_mux             = out_b.pc_mux;
   assign decoded_ret                = out_b.ret;
   assign decoded_reg_input_mux      = out_b.reg_input_mux;
   assign decoded_alu_arithmetic_mux = out_b.alu_arithmetic_mux;
   assign decoded_illegal            = out_b.illegal;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Bench for instr_decoder_pipe: directed scenarios plus random traffic against
// a queue-based model of the decoder pipeline.
module tb_instr_decoder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, flush, in_valid, out_ready;
   logic [15:0] instruction;
   logic        in_ready, out_valid;
   logic [3:0]  d_rd, d_rs, d_rt;
   logic [2:0]  d_nzp;
   logic [7:0]  d_imm;
   logic        d_reg_we, d_mem_re, d_mem_we, d_nzp_we, d_alu_out, d_pc_mux, d_ret, d_ill;
   logic [1:0]  d_rim, d_aam;
   logic        halted;
   logic [15:0] decode_count;

   logic        w_flush, w_in_valid, w_out_ready;
   logic [19:0] w_instruction;
   logic        w_in_ready, w_out_valid;
   logic [4:0]  w_rd, w_rs, w_rt;
   logic [2:0]  w_nzp;
   logic [11:0] w_imm;
   logic        w_reg_we, w_mem_re, w_mem_we, w_nzp_we, w_alu_out, w_pc_mux, w_ret, w_ill;
   logic [1:0]  w_rim, w_aam;
   logic        w_halted;
   logic [3:0]  w_decode_count;

   instr_decoder_pipe dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
      .decoded_rd_address(d_rd), .decoded_rs_address(d_rs), .decoded_rt_address(d_rt),
      .decoded_nzp(d_nzp), .decoded_immediate(d_imm),
      .decoded_reg_write_enable(d_reg_we), .decoded_mem_read_enable(d_mem_re),
      .decoded_mem_write_enable(d_mem_we), .decoded_nzp_write_enable(d_nzp_we),
      .decoded_alu_output_mux(d_alu_out), .decoded_pc_mux(d_pc_mux), .decoded_ret(d_ret),
      .decoded_reg_input_mux(d_rim), .decoded_alu_arithmetic_mux(d_aam),
      .decoded_illegal(d_ill), .halted(halted), .decode_count(decode_count)
   );

   instr_decoder_pipe #(
      .REG_ADDR_WIDTH(5), .IMM_WIDTH(12), .INSTR_WIDTH(20), .COUNT_WIDTH(4)
   ) dut_w (
      .clk(clk), .reset(reset), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .instruction(w_instruction), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .decoded_rd_address(w_rd), .decoded_rs_address(w_rs), .decoded_rt_address(w_rt),
      .decoded_nzp(w_nzp), .decoded_immediate(w_imm),
      .decoded_reg_write_enable(w_reg_we), .decoded_mem_read_enable(w_mem_re),
      .decoded_mem_write_enable(w_mem_we), .decoded_nzp_write_enable(w_nzp_we),
      .decoded_alu_output_mux(w_alu_out), .decoded_pc_mux(w_pc_mux), .decoded_ret(w_ret),
      .decoded_reg_input_mux(w_rim), .decoded_alu_arithmetic_mux(w_aam),
      .decoded_illegal(w_ill), .halted(w_halted), .decode_count(w_decode_count)
   );

   // ctrl = {reg_we, mem_re, mem_we, nzp_we, alu_out, pc_mux, ret}
   typedef struct packed {
      logic [7:0]  rd, rs, rt;
      logic [2:0]  nzp;
      logic [15:0] imm;
      logic [6:0]  ctrl;
      logic [1:0]  rim, aam;
      logic        ill;
   } bundle_t;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   bundle_t     q[$];
   logic        m_halted = 1'b0;
   logic [15:0] m_count  = '0;

   function automatic bundle_t ref_decode(input logic [31:0] instr, input int w, input int r,
                                          input int iw);
      bundle_t b;
      int      op;
      b     = '0;
      op    = int'((instr >> (w - 4)) % 32'd16);
      b.rd  = 8'((instr >> (w - 4 - r)) % (32'd1 << r));
      b.rs  = 8'((instr >> (w - 4 - 2*r)) % (32'd1 << r));
      b.rt  = 8'((instr >> (w - 4 - 3*r)) % (32'd1 << r));
      b.nzp = 3'(b.rd >> (r - 3));
      b.imm = 16'(instr % (32'd1 << iw));
      case (op)
         0:          ;
         1:          b.ctrl = 7'b0000010;
         2:          b.ctrl = 7'b0001100;
         3, 4, 5, 6: begin b.ctrl = 7'b1000000; b.aam = 2'(op - 3); end
         7:          begin b.ctrl = 7'b1100000; b.rim = 2'b01; end
         8:          b.ctrl = 7'b0010000;
         9:          begin b.ctrl = 7'b1000000; b.rim = 2'b10; end
         15:         b.ctrl = 7'b0000001;
         default:    b.ill = 1'b1;
      endcase
      return b;
   endfunction

   function automatic bundle_t obs_d();
      bundle_t b;
      b.rd = 8'(d_rd); b.rs = 8'(d_rs); b.rt = 8'(d_rt); b.nzp = d_nzp; b.imm = 16'(d_imm);
      b.ctrl = {d_reg_we, d_mem_re, d_mem_we, d_nzp_we, d_alu_out, d_pc_mux, d_ret};
      b.rim = d_rim; b.aam = d_aam; b.ill = d_ill;
      return b;
   endfunction

   function automatic bundle_t obs_w();
      bundle_t b;
      b.rd = 8'(w_rd); b.rs = 8'(w_rs); b.rt = 8'(w_rt); b.nzp = w_nzp; b.imm = 16'(w_imm);
      b.ctrl = {w_reg_we, w_mem_re, w_mem_we, w_nzp_we, w_alu_out, w_pc_mux, w_ret};
      b.rim = w_rim; b.aam = w_aam; b.ill = w_ill;
      return b;
   endfunction

   function automatic logic exp_valid();
      return q.size() != 0;
   endfunction

   function automatic logic exp_ready();
      return !reset && !flush && !m_halted && (q.size() < 2);
   endfunction

   task automatic drive(input logic iv, input logic [15:0] ins, input logic ordy,
                        input logic fl, input logic rst);
      in_valid = iv; instruction = ins; out_ready = ordy; flush = fl; reset = rst;
      #1;
   endtask

   // Model update for the coming edge, then step to just after it.
   task automatic advance();
      logic ofire, ifire;
      if (reset) begin
         q.delete(); m_halted = 1'b0; m_count = '0;
      end else begin
         ofire = exp_valid() && out_ready;
         ifire = in_valid && exp_ready();
         if (ofire) m_count = m_count + 16'd1;
         if (flush) begin
            q.delete(); m_halted = 1'b0;
         end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) begin
               q.push_back(ref_decode(32'(instruction), 16, 4, 8));
               if (instruction[15:12] == 4'hF) m_halted = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 16'h3123, 1'b1, 1'b0, 1'b1);
      advance();
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);
         n_checks++;
         if ({in_ready, out_valid} !== 2'b00)
            $display("FAIL reset_hold cyc %0d: got rdy=%b vld=%b want 0 0", c, in_ready, out_valid);
         else n_pass++;
         advance();
      end
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({in_ready, out_valid, halted, decode_count} !== {1'b1, 1'b0, 1'b0, 16'd0})
         $display("FAIL reset_state: got rdy=%b vld=%b hlt=%b cnt=%0d want 1 0 0 0",
                  in_ready, out_valid, halted, decode_count);
      else n_pass++;
      n_checks++;
      if (obs_d() !== bundle_t'(0)) $display("FAIL reset_bundle: got %h want 0", obs_d());
      else n_pass++;
      n_checks++;
      if ({w_in_ready, w_out_valid, w_halted, w_decode_count} !== {1'b1, 1'b0, 1'b0, 4'd0})
         $display("FAIL reset_wide: got rdy=%b vld=%b hlt=%b cnt=%0d want 1 0 0 0",
                  w_in_ready, w_out_valid, w_halted, w_decode_count);
      else n_pass++;
      advance();
   endtask

   task automatic test_add();
      bit          iv_t [3];
      logic [15:0] ins_t[3];
      iv_t  = '{1'b1, 1'b0, 1'b0};
      ins_t = '{16'h3123, 16'h0000, 16'h0000};
      for (int c = 0; c < 3; c++) begin
         drive(iv_t[c], ins_t[c], 1'b1, 1'b0, 1'b0);
         n_checks++;
         if ({in_ready, out_valid, halted, decode_count} !== {exp_ready(), exp_valid(), m_halted, m_count})
            $display("FAIL add status cyc %0d: got rdy=%b vld=%b hlt=%b cnt=%0d want rdy=%b vld=%b hlt=%b cnt=%0d",
                     c, in_ready, out_valid, halted, decode_count, exp_ready(), exp_valid(), m_halted, m_count);
         else n_pass++;
         if (exp_valid()) begin
            n_checks++;
            if (obs_d() !== q[0]) $display("FAIL add bundle cyc %0d: got %h want %h", c, obs_d(), q[0]);
            else n_pass++;
         end
         if (c == 1) begin
            n_checks++;
            if ({out_valid, d_rd, d_rs, d_rt, d_reg_we, d_aam} !== {1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 2'b00})
               $display("FAIL add fields: got vld=%b rd=%0d rs=%0d rt=%0d we=%b aam=%b want 1 1 2 3 1 00",
                        out_valid, d_rd, d_rs, d_rt, d_reg_we, d_aam);
            else n_pass++;
         end
         if (c == 2) begin
            n_checks++;
            if (decode_count !== 16'd1) $display("FAIL add count: got %0d want 1", decode_count);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      bit          iv_t [7];
      bit          or_t [7];
      logic [15:0] ins_t[7];
      iv_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      or_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      ins_t = '{16'h7450, 16'h9A2F, 16'h1E05, 16'h1E05, 16'h1E05, 16'h0000, 16'h0000};
      for (int c = 0; c < 7; c++) begin
         drive(iv_t[c], ins_t[c], or_t[c], 1'b0, 1'b0);
         n_checks++;
         if ({in_ready, out_valid, halted, decode_count} !== {exp_ready(), exp_valid(), m_halted, m_count})
            $display("FAIL b2b status cyc %0d: got rdy=%b vld=%b hlt=%b cnt=%0d want rdy=%b vld=%b hlt=%b cnt=%0d",
                     c, in_ready, out_valid, halted, decode_count, exp_ready(), exp_valid(), m_halted, m_count);
         else n_pass++;
         if (exp_valid()) begin
            n_checks++;
            if (obs_d() !== q[0]) $display("FAIL b2b bundle cyc %0d: got %h want %h", c, obs_d(), q[0]);
            else n_pass++;
         end
         if (c == 2) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL b2b full: got in_ready=%b want 0", in_ready);
            else n_pass++;
         end
         if (c == 3) begin
            n_checks++;
            if ({d_mem_re, d_rim} !== {1'b1, 2'b01})
               $display("FAIL b2b ldr: got mem_re=%b rim=%b want 1 01", d_mem_re, d_rim);
            else n_pass++;
         end
         if (c == 4) begin
            n_checks++;
            if ({d_imm, d_rim} !== {8'h2F, 2'b10})
               $display("FAIL b2b const: got imm=%h rim=%b want 2f 10", d_imm, d_rim);
            else n_pass++;
         end
         if (c == 5) begin
            n_checks++;
            if ({out_valid, d_nzp, d_pc_mux} !== {1'b1, 3'b111, 1'b1})
               $display("FAIL b2b br: got vld=%b nzp=%b pc_mux=%b want 1 111 1", out_valid, d_nzp, d_pc_mux);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_illegal();
      bit          iv_t [3];
      logic [15:0] ins_t[3];
      iv_t  = '{1'b1, 1'b0, 1'b0};
      ins_t = '{16'hB000, 16'h0000, 16'h0000};
      for (int c = 0; c < 3; c++) begin
         drive(iv_t[c], ins_t[c], 1'b1, 1'b0, 1'b0);
         n_checks++;
         if ({in_ready, out_valid, halted, decode_count} !== {exp_ready(), exp_valid(), m_halted, m_count})
            $display("FAIL illegal status cyc %0d: got rdy=%b vld=%b hlt=%b cnt=%0d want rdy=%b vld=%b hlt=%b cnt=%0d",
                     c, in_ready, out_valid, halted, decode_count, exp_ready(), exp_valid(), m_halted, m_count);
         else n_pass++;
         if (exp_valid()) begin
            n_checks++;
            if (obs_d() !== q[0]) $display("FAIL illegal bundle cyc %0d: got %h want %h", c, obs_d(), q[0]);
            else n_pass++;
         end
         if (c == 1) begin
            n_checks++;
            if ({d_ill, obs_d().ctrl, d_rim, d_aam} !== {1'b1, 11'd0})
               $display("FAIL illegal ctrl: got ill=%b ctrl=%b rim=%b aam=%b want 1 0 0 0",
                        d_ill, obs_d().ctrl, d_rim, d_aam);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_ret_halt();
      bit          iv_t [7];
      bit          fl_t [7];
      logic [15:0] ins_t[7];
      iv_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      fl_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      ins_t = '{16'hF000, 16'h3123, 16'h3123, 16'h3123, 16'h3123, 16'h0000, 16'h0000};
      for (int c = 0; c < 7; c++) begin
         drive(iv_t[c], ins_t[c], 1'b1, fl_t[c], 1'b0);
         n_checks++;
         if ({in_ready, out_valid, halted, decode_count} !== {exp_ready(), exp_valid(), m_halted, m_count})
            $display("FAIL ret status cyc %0d: got rdy=%b vld=%b hlt=%b cnt=%0d want rdy=%b vld=%b hlt=%b cnt=%0d",
                     c, in_ready, out_valid, halted, decode_count, exp_ready(), exp_valid(), m_halted, m_count);
         else n_pass++;
         if (exp_valid()) begin
            n_checks++;
            if (obs_d() !== q[0]) $display("FAIL ret bundle cyc %0d: got %h want %h", c, obs_d(), q[0]);
            else n_pass++;
         end
         if (c == 1) begin
            n_checks++;
            if ({halted, in_ready, out_valid, d_ret} !== 4'b1011)
               $display("FAIL ret halt: got hlt=%b rdy=%b vld=%b ret=%b want 1 0 1 1",
                        halted, in_ready, out_valid, d_ret);
            else n_pass++;
         end
         if (c == 5) begin
            n_checks++;
            if ({halted, out_valid, d_rd, d_reg_we} !== {1'b0, 1'b1, 4'd1, 1'b1})
               $display("FAIL ret resume: got hlt=%b vld=%b rd=%0d we=%b want 0 1 1 1",
                        halted, out_valid, d_rd, d_reg_we);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_flush_full();
      bit          iv_t [7];
      bit          or_t [7];
      bit          fl_t [7];
      logic [15:0] ins_t[7];
      logic [15:0] cnt0;
      iv_t  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      or_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      fl_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      ins_t = '{16'h7450, 16'h9A2F, 16'h0000, 16'h0000, 16'h3123, 16'h0000, 16'h0000};
      cnt0  = m_count;
      for (int c = 0; c < 7; c++) begin
         drive(iv_t[c], ins_t[c], or_t[c], fl_t[c], 1'b0);
         n_checks++;
         if ({in_ready, out_valid, halted, decode_count} !== {exp_ready(), exp_valid(), m_halted, m_count})
            $display("FAIL flush status cyc %0d: got rdy=%b vld=%b hlt=%b cnt=%0d want rdy=%b vld=%b hlt=%b cnt=%0d",
                     c, in_ready, out_valid, halted, decode_count, exp_ready(), exp_valid(), m_halted, m_count);
         else n_pass++;
         if (exp_valid()) begin
            n_checks++;
            if (obs_d() !== q[0]) $display("FAIL flush bundle cyc %0d: got %h want %h", c, obs_d(), q[0]);
            else n_pass++;
         end
         if (c == 3) begin
            n_checks++;
            if ({out_valid, in_ready, decode_count} !== {1'b0, 1'b1, cnt0})
               $display("FAIL flush empty: got vld=%b rdy=%b cnt=%0d want 0 1 %0d",
                        out_valid, in_ready, decode_count, cnt0);
            else n_pass++;
         end
         if (c == 6) begin
            n_checks++;
            if ({out_valid, decode_count} !== {1'b0, 16'(cnt0 + 16'd1)})
               $display("FAIL flush fire_counts: got vld=%b cnt=%0d want 0 %0d",
                        out_valid, decode_count, cnt0 + 16'd1);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      bit          iv_t [4];
      bit          or_t [4];
      bit          rs_t [4];
      logic [15:0] ins_t[4];
      iv_t  = '{1'b1, 1'b1, 1'b0, 1'b0};
      or_t  = '{1'b0, 1'b0, 1'b0, 1'b1};
      rs_t  = '{1'b0, 1'b0, 1'b1, 1'b0};
      ins_t = '{16'h7450, 16'h9A2F, 16'h0000, 16'h0000};
      for (int c = 0; c < 4; c++) begin
         drive(iv_t[c], ins_t[c], or_t[c], 1'b0, rs_t[c]);
         n_checks++;
         if ({in_ready, out_valid} !== {exp_ready(), exp_valid()})
            $display("FAIL rstmid status cyc %0d: got rdy=%b vld=%b want rdy=%b vld=%b",
                     c, in_ready, out_valid, exp_ready(), exp_valid());
         else n_pass++;
         if (c == 3) begin
            n_checks++;
            if ({out_valid, in_ready, halted, decode_count} !== {1'b0, 1'b1, 1'b0, 16'd0})
               $display("FAIL rstmid cleared: got vld=%b rdy=%b hlt=%b cnt=%0d want 0 1 0 0",
                        out_valid, in_ready, halted, decode_count);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0,
               ($urandom % 20) == 0, ($urandom % 97) == 0);
         if (!reset) begin
            n_checks++;
            if ({in_ready, out_valid, halted, decode_count} !== {exp_ready(), exp_valid(), m_halted, m_count})
               $display("FAIL rand status cyc %0d: got rdy=%b vld=%b hlt=%b cnt=%0d want rdy=%b vld=%b hlt=%b cnt=%0d",
                        c, in_ready, out_valid, halted, decode_count, exp_ready(), exp_valid(), m_halted, m_count);
            else n_pass++;
            if (exp_valid()) begin
               n_checks++;
               if (obs_d() !== q[0]) $display("FAIL rand bundle cyc %0d: got %h want %h", c, obs_d(), q[0]);
               else n_pass++;
            end
         end
         advance();
      end
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      advance();
   endtask

   task automatic test_wide();
      bundle_t wexp;
      wexp = ref_decode(32'h48A5C, 20, 5, 12);
      w_in_valid = 1'b1; w_instruction = 20'h48A5C; w_out_ready = 1'b1;
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         advance();
         if (k == 1) begin
            n_checks++;
            if ({w_out_valid, w_decode_count} !== {1'b1, 4'd0} || obs_w() !== wexp)
               $display("FAIL wide bundle: got vld=%b cnt=%0d %h want 1 0 %h",
                        w_out_valid, w_decode_count, obs_w(), wexp);
            else n_pass++;
            n_checks++;
            if ({w_rd, w_rs, w_rt, w_imm, w_aam} !== {5'b10001, 5'b01001, 5'b01110, 12'hA5C, 2'b01})
               $display("FAIL wide fields: got rd=%b rs=%b rt=%b imm=%h aam=%b want 10001 01001 01110 a5c 01",
                        w_rd, w_rs, w_rt, w_imm, w_aam);
            else n_pass++;
         end
         if (k == 16) begin
            w_in_valid = 1'b0;
            n_checks++;
            if (w_decode_count !== 4'hF) $display("FAIL wide count_max: got %0d want 15", w_decode_count);
            else n_pass++;
         end
         if (k == 17) begin
            n_checks++;
            if ({w_out_valid, w_decode_count} !== {1'b0, 4'd0})
               $display("FAIL wide wrap: got vld=%b cnt=%0d want 0 0", w_out_valid, w_decode_count);
            else n_pass++;
         end
      end
   endtask

   initial begin
      w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0; w_instruction = '0;
      in_valid = 1'b0; instruction = '0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;
      test_reset();
      test_add();
      test_back_to_back();
      test_illegal();
      test_ret_halt();
      test_flush_full();
      test_reset_mid();
      test_random();
      test_wide();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
